regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_mp.sv | 82 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the multi-port register file.
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    typedef enum logic [1:0] {RST, CLEAR, READY} rf_state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read ports, write-back and scoreboard-set bus of the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2
);
    localparam int AW = $clog2(NREGS);
    logic [NRD-1:0][AW-1:0] rs_sel;
    logic [NRD-1:0][XLEN-1:0] rs_data;
    logic [NRD-1:0] rs_busy;
    logic reg_write;
    logic [AW-1:0] rd_sel;
    logic [XLEN-1:0] wb_data;
    logic sb_set;
    logic [AW-1:0] sb_addr;
    logic ready;
    modport master (
        output rs_sel, reg_write, rd_sel, wb_data, sb_set, sb_addr,
        input rs_data, rs_busy, ready
    );
    modport slave (
        input rs_sel, reg_write, rd_sel, wb_data, sb_set, sb_addr,
        output rs_data, rs_busy, ready
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with sweep clear, write clear, set-wins marking and lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_idx,
    input  logic wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic set_en,
    input  logic [$clog2(NREGS)-1:0] set_addr,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0] rs_sel,
    output logic [NRD-1:0] busy
);
    logic [NREGS-1:0] busy_q, busy_d;

    // set is applied after the write clear so a same-cycle producer keeps the bit
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        else begin
            if (wr_en) busy_d[wr_addr] = 1'b0;
            if (set_en) busy_d[set_addr] = 1'b1;
        end
        for (int i = 0; i < NRD; i++) busy[i] = busy_q[rs_sel[i]];
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= busy_d;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with startup clear sweep and scoreboard busy bits.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2
) (
    input logic clk,
    input logic reset,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    rf_state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic ready, clearing, wr_en, set_en;
    logic [NRD-1:0] sb_busy, byp, rd_busy;
    logic [NRD-1:0][XLEN-1:0] rd_data;

    assign ready = state_q == READY;
    assign clearing = state_q == CLEAR;
    assign wr_en = ready && bus.reg_write && bus.rd_sel != '0;
    assign set_en = ready && bus.sb_set && bus.sb_addr != '0;

    always_comb begin
        state_d = state_q == RST ? CLEAR : (clearing && idx_q == AW'(NREGS - 1)) ? READY : state_q;
        idx_d = clearing ? idx_q + 1'b1 : '0;
        regs_d = regs_q;
        if (clearing) regs_d[idx_q] = '0;
        else if (wr_en) regs_d[bus.rd_sel] = bus.wb_data;
    end

    // the array is only held during reset; zeroing is left to the sweep
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RST;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
        .clk(clk),
        .reset(reset),
        .clr_en(clearing),
        .clr_idx(idx_q),
        .wr_en(wr_en),
        .wr_addr(bus.rd_sel),
        .set_en(set_en),
        .set_addr(bus.sb_addr),
        .rs_sel(bus.rs_sel),
        .busy(sb_busy)
    );

    always_comb begin
        byp = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_MP_BYPASS_EN
            byp[i] = wr_en && bus.rd_sel == bus.rs_sel[i];
`else
            byp[i] = 1'b0;
`endif
            if (ready && bus.rs_sel[i] != '0) begin
                rd_data[i] = byp[i] ? bus.wb_data : regs_q[bus.rs_sel[i]];
                rd_busy[i] = !byp[i] && sb_busy[i];
            end
        end
    end

    assign bus.rs_data = rd_data;
    assign bus.rs_busy = rd_busy;
    assign bus.ready = ready;
endmodule
